addr_mgmt_pool: RTL and testbench
=================================

// Module: addr_mgmt_pool
// PURPOSE
//  Parametrised free-list manager for the data_cache buffer pool; next generation of the fixed 32-ID manager.
//  Hands out free buffer IDs plus block base write addresses to the input path.
//  Accepts released IDs plus read base addresses from the output path.
//  Adds range and double-free protection, live free/used counts and a low-watermark flag for back-pressure.
// PARAMETERS
//  ID_W      5    width of a buffer ID
//  NUM_ID    32   IDs in pool (2..2**ID_W); IDs 0..NUM_ID-1 are valid
//  BLK_SHIFT 7    log2 of words per buffer block; base addr = id << BLK_SHIFT
//  ADDR_W    12   data_cache address width (>= ID_W+BLK_SHIFT)
//  LOW_TH    4    free_low asserted when free_cnt <= LOW_TH
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          async active-low reset
//  init_done    out  1          free list initialised
//  alloc_vld    out  1          alloc_id/alloc_waddr hold a free ID (show-ahead)
//  alloc_id     out  ID_W       head ID of free list
//  alloc_waddr  out  ADDR_W     {alloc_id, BLK_SHIFT'b0}, zero-extended
//  alloc_req    in   1          consume head ID this cycle; ignored when alloc_vld=0
//  free_wr      in   1          release request, single-cycle pulse per ID
//  free_id      in   ID_W       ID being released
//  rd_raddr     out  ADDR_W     read base addr of last accepted release
//  rd_raddr_wr  out  1          1-cycle strobe for rd_raddr
//  free_cnt     out  ID_W+1     IDs currently in free list
//  free_low     out  1          free_cnt <= LOW_TH (registered)
//  err_range    out  1          1-cycle pulse: free_id >= NUM_ID dropped
//  err_dfree    out  1          1-cycle pulse: free of already-free ID dropped
// BEHAVIOUR
//  Reset: all outputs 0; used bitmap all 1; free-list pointers 0; FSM=INIT.
//  Mid-operation reset restarts INIT and discards all state.
//  Storage: circular list of NUM_ID x ID_W entries.
//  - wr_ptr/rd_ptr wrap at NUM_ID, not at a power of 2.
//  - free_cnt tracks occupancy; the list is full at NUM_ID and never overflows.
//  FSM INIT: one entry per cycle, writes ID k at cycle k for k=0..NUM_ID-1, clearing used[k].
//  - Then INIT->RUN; init_done=1 from the next cycle; free_cnt=NUM_ID.
//  - alloc_req, free_wr and alloc_vld are ignored/held low during INIT.
//  RUN: alloc_vld = init_done & (free_cnt!=0).
//  - alloc_id is valid in the same cycle as alloc_vld.
//  - alloc_req with alloc_vld: pop, set used[alloc_id], and next head is shown the following cycle.
//  - Empty list: alloc_vld=0 and alloc_req has no effect.
//  Release check, one cycle after free_wr:
//  - free_id>=NUM_ID: err_range=1, list untouched.
//  - Else used[free_id]=0: err_dfree=1, list untouched.
//  - Else push free_id, clear used, rd_raddr=free_id<<BLK_SHIFT, rd_raddr_wr=1.
//  Simultaneous pop and push in one cycle:
//  - Both are performed and free_cnt is unchanged.
//  - A pop on an empty list never consumes the ID pushed that same cycle; it shows as head next cycle.
//  - Double-free check uses the used bitmap before the same-cycle pop update.
//  Latency: alloc = 0 cycles (show-ahead); release -> rd_raddr_wr = 1 cycle.
//  - free_cnt and free_low update 1 cycle after the event.
//  Throughput: one pop plus one push per cycle sustained.
// TESTING
//  Reset, then idle 40 cycles -> init_done rises at cycle 33; free_cnt=32; alloc_id=0; alloc_waddr=0x000.
//  32 back-to-back alloc_req -> IDs 0..31 in order, waddr 0x000..0xF80, alloc_vld=0 after the last.
//  free_cnt reaches 0; free_low set when free_cnt<=4.
//  Empty pool, free_wr id=9 with alloc_req held:
//  - rd_raddr=0x480 and rd_raddr_wr pulse one cycle later.
//  - Next cycle alloc_id=9 popped; free_cnt 0->1->0.
//  free_wr id=3 twice (3 allocated once) -> first accepted; second gives err_dfree=1 and free_cnt +1 only.
//  free_wr id=40 with NUM_ID=32, ID_W=6 -> err_range=1, no rd_raddr_wr, free_cnt unchanged.
//  NUM_ID=24 wrap: alloc/free 100 random IDs keeping used<=24 -> no duplicate allocations.
//  - Also check ptr wrap 23->0 and assert rst_n low mid-run -> outputs 0, INIT restarts.

Source files
------------

// File: rtl/addr_mgmt_pool.sv
// Free-list manager for the data_cache buffer pool: show-ahead allocation of buffer IDs,
// checked release with range and double-free protection, live occupancy and low-watermark.
module addr_mgmt_pool #(
  parameter int unsigned ID_W      = 5,
  parameter int unsigned NUM_ID    = 32,
  parameter int unsigned BLK_SHIFT = 7,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned LOW_TH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  output logic              alloc_vld,
  output logic [ID_W-1:0]   alloc_id,
  output logic [ADDR_W-1:0] alloc_waddr,
  input  logic              alloc_req,
  input  logic              free_wr,
  input  logic [ID_W-1:0]   free_id,
  output logic [ADDR_W-1:0] rd_raddr,
  output logic              rd_raddr_wr,
  output logic [ID_W:0]     free_cnt,
  output logic              free_low,
  output logic              err_range,
  output logic              err_dfree
);

  localparam int unsigned PTR_W = (NUM_ID > 1) ? $clog2(NUM_ID) : 1;
  localparam int unsigned CNT_W = ID_W + 1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     mem_q [NUM_ID];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_ID-1:0]   used_q, used_d;
  logic                init_done_q, init_done_d;
  logic [ADDR_W-1:0]   rd_raddr_q, rd_raddr_d;
  logic                rd_raddr_wr_q, rd_raddr_wr_d;
  logic                err_range_q, err_range_d;
  logic                err_dfree_q, err_dfree_d;
  logic                free_low_q, free_low_d;

  logic                mem_we;
  logic [ID_W-1:0]     mem_wdata;
  logic                pop, push, rel, in_range, used_bit;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (32'(p) == NUM_ID - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [ID_W-1:0] id);
    return ADDR_W'(id) << BLK_SHIFT;
  endfunction

  assign alloc_vld   = init_done_q && (cnt_q != '0);
  assign alloc_id    = mem_q[rd_ptr_q];
  assign alloc_waddr = addr_of(alloc_id);

  assign pop      = alloc_req && alloc_vld;
  assign rel      = free_wr && init_done_q;
  assign in_range = 32'(free_id) < NUM_ID;
  // Low bits are a safe index only once the ID is known to be in range.
  assign used_bit = in_range ? used_q[free_id[PTR_W-1:0]] : 1'b0;
  assign push     = rel && in_range && used_bit;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    used_d        = used_q;
    init_done_d   = init_done_q;
    rd_raddr_d    = rd_raddr_q;
    rd_raddr_wr_d = 1'b0;
    err_range_d   = 1'b0;
    err_dfree_d   = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    unique case (state_q)
      StInit: begin
        mem_we           = 1'b1;
        mem_wdata        = ID_W'(wr_ptr_q);
        used_d[wr_ptr_q] = 1'b0;
        wr_ptr_d         = next_ptr(wr_ptr_q);
        cnt_d            = cnt_q + 1'b1;
        if (32'(wr_ptr_q) == NUM_ID - 1) state_d = StRun;
      end
      StRun: begin
        init_done_d = 1'b1;
        if (pop) begin
          rd_ptr_d                         = next_ptr(rd_ptr_q);
          used_d[alloc_id[PTR_W-1:0]]      = 1'b1;
        end
        if (push) begin
          mem_we                           = 1'b1;
          mem_wdata                        = free_id;
          used_d[free_id[PTR_W-1:0]]       = 1'b0;
          wr_ptr_d                         = next_ptr(wr_ptr_q);
          rd_raddr_d                       = addr_of(free_id);
          rd_raddr_wr_d                    = 1'b1;
        end
        err_range_d = rel && !in_range;
        err_dfree_d = rel && in_range && !used_bit;
        cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
      default: state_d = StInit;
    endcase
    free_low_d = (state_q == StRun) && (32'(cnt_d) <= LOW_TH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StInit;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      used_q        <= '1;
      init_done_q   <= 1'b0;
      rd_raddr_q    <= '0;
      rd_raddr_wr_q <= 1'b0;
      err_range_q   <= 1'b0;
      err_dfree_q   <= 1'b0;
      free_low_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_ID; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      used_q        <= used_d;
      init_done_q   <= init_done_d;
      rd_raddr_q    <= rd_raddr_d;
      rd_raddr_wr_q <= rd_raddr_wr_d;
      err_range_q   <= err_range_d;
      err_dfree_q   <= err_dfree_d;
      free_low_q    <= free_low_d;
      if (mem_we) mem_q[wr_ptr_q] <= mem_wdata;
    end
  end

  assign init_done   = init_done_q;
  assign rd_raddr    = rd_raddr_q;
  assign rd_raddr_wr = rd_raddr_wr_q;
  assign free_cnt    = cnt_q;
  assign free_low    = free_low_q;
  assign err_range   = err_range_q;
  assign err_dfree   = err_dfree_q;

endmodule

// File: tb/tb_addr_mgmt_pool.sv
// Randomised bench for addr_mgmt_pool: a queue-based free-list model checked every cycle,
// plus directed literal checks for init timing, drain, release errors and mid-run reset.
module tb_addr_mgmt_pool;

  localparam int ID_W   = 6;
  localparam int NUM_ID = 24;
  localparam int BLK    = 7;
  localparam int ADDR_W = 13;
  localparam int LOW_TH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              init_done, alloc_vld, alloc_req, free_wr;
  logic [ID_W-1:0]   alloc_id, free_id;
  logic [ADDR_W-1:0] alloc_waddr, rd_raddr;
  logic              rd_raddr_wr, free_low, err_range, err_dfree;
  logic [ID_W:0]     free_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  addr_mgmt_pool #(
    .ID_W(ID_W), .NUM_ID(NUM_ID), .BLK_SHIFT(BLK), .ADDR_W(ADDR_W), .LOW_TH(LOW_TH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .alloc_vld(alloc_vld),
    .alloc_id(alloc_id), .alloc_waddr(alloc_waddr), .alloc_req(alloc_req),
    .free_wr(free_wr), .free_id(free_id), .rd_raddr(rd_raddr), .rd_raddr_wr(rd_raddr_wr),
    .free_cnt(free_cnt), .free_low(free_low), .err_range(err_range), .err_dfree(err_dfree)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a FIFO of free IDs and an allocated-set bitmap.
  int m_q[$];
  bit m_used[NUM_ID];
  int m_edges;
  bit m_done, m_low, m_rdw, m_er, m_ed;
  int m_raddr;

  task automatic model_step();
    bit do_pop, acc;
    int fid, x;
    m_rdw = 0; m_er = 0; m_ed = 0;
    if (m_edges < NUM_ID) begin
      m_q.push_back(m_edges);
      m_used[m_edges] = 0;
      m_edges++;
    end else if (!m_done) begin
      m_done = 1;
    end else begin
      do_pop = alloc_req && (m_q.size() > 0);
      acc = 0;
      fid = int'(free_id);
      if (free_wr) begin
        if (fid >= NUM_ID) m_er = 1;
        else if (!m_used[fid]) m_ed = 1;
        else acc = 1;
      end
      if (do_pop) begin
        x = m_q.pop_front();
        m_used[x] = 1;
      end
      if (acc) begin
        m_q.push_back(fid);
        m_used[fid] = 0;
        m_raddr = fid << BLK;
        m_rdw = 1;
      end
    end
    m_low = m_done && (m_q.size() <= LOW_TH);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      foreach (m_used[i]) m_used[i] = 1;
      m_edges = 0; m_done = 0; m_low = 0; m_rdw = 0; m_er = 0; m_ed = 0; m_raddr = 0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("init_done", 32'(init_done), 32'(m_done));
      chk("alloc_vld", 32'(alloc_vld), 32'(m_done && m_q.size() != 0));
      if (m_done && m_q.size() != 0) begin
        chk("alloc_id", 32'(alloc_id), 32'(m_q[0]));
        chk("alloc_waddr", 32'(alloc_waddr), 32'(m_q[0] << BLK));
      end
      chk("free_cnt", 32'(free_cnt), 32'(m_q.size()));
      chk("free_low", 32'(free_low), 32'(m_low));
      chk("rd_raddr_wr", 32'(rd_raddr_wr), 32'(m_rdw));
      chk("rd_raddr", 32'(rd_raddr), 32'(m_raddr));
      chk("err_range", 32'(err_range), 32'(m_er));
      chk("err_dfree", 32'(err_dfree), 32'(m_ed));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_init_done"}, 32'(init_done), 0);
    chk({tag, "_alloc_vld"}, 32'(alloc_vld), 0);
    chk({tag, "_alloc_id"}, 32'(alloc_id), 0);
    chk({tag, "_free_cnt"}, 32'(free_cnt), 0);
    chk({tag, "_free_low"}, 32'(free_low), 0);
    chk({tag, "_rd_raddr"}, 32'(rd_raddr), 0);
    chk({tag, "_rd_raddr_wr"}, 32'(rd_raddr_wr), 0);
    chk({tag, "_err"}, 32'({err_range, err_dfree}), 0);
  endtask

  task automatic random_phase(input int cycles, input int alloc_pct);
    int used_list[$];
    int r;
    for (int c = 0; c < cycles; c++) begin
      used_list.delete();
      for (int i = 0; i < NUM_ID; i++) if (m_used[i]) used_list.push_back(i);
      alloc_req = ($urandom_range(0, 99) < alloc_pct);
      r = $urandom_range(0, 99);
      free_wr = 1'b1;
      if (r < 40 && used_list.size() > 0)
        free_id = ID_W'(used_list[$urandom_range(0, used_list.size() - 1)]);
      else if (r < 45) free_id = ID_W'($urandom_range(NUM_ID, (1 << ID_W) - 1));
      else if (r < 52) free_id = ID_W'($urandom_range(0, NUM_ID - 1));
      else begin
        free_wr = 1'b0;
        free_id = '0;
      end
      cyc();
    end
    alloc_req = 1'b0;
    free_wr = 1'b0;
  endtask

  initial begin
    alloc_req = 1'b0;
    free_wr = 1'b0;
    free_id = '0;
    repeat (3) cyc();
    check_zero("reset");
    rst_n = 1'b1;

    // Initialisation timing: list full after NUM_ID edges, init_done one edge later.
    repeat (NUM_ID) cyc();
    chk("init_pending", 32'(init_done), 0);
    chk("init_cnt", 32'(free_cnt), NUM_ID);
    cyc();
    chk("init_done_rise", 32'(init_done), 1);
    chk("init_vld", 32'(alloc_vld), 1);
    chk("init_head", 32'(alloc_id), 0);
    chk("init_waddr", 32'(alloc_waddr), 0);
    repeat (40 - NUM_ID - 1) cyc();

    // Drain the pool back-to-back; IDs come out in order.
    alloc_req = 1'b1;
    for (int k = 0; k < NUM_ID; k++) begin
      chk("drain_id", 32'(alloc_id), 32'(k));
      chk("drain_waddr", 32'(alloc_waddr), 32'(k << BLK));
      cyc();
    end
    chk("drain_vld", 32'(alloc_vld), 0);
    chk("drain_cnt", 32'(free_cnt), 0);
    chk("drain_low", 32'(free_low), 1);

    // Release into an empty pool while alloc_req stays high.
    free_wr = 1'b1;
    free_id = 6'd9;
    cyc();
    chk("rel9_strobe", 32'(rd_raddr_wr), 1);
    chk("rel9_raddr", 32'(rd_raddr), 32'h480);
    chk("rel9_cnt", 32'(free_cnt), 1);
    chk("rel9_head", 32'(alloc_id), 9);
    free_wr = 1'b0;
    cyc();
    chk("rel9_popped_cnt", 32'(free_cnt), 0);
    chk("rel9_strobe_off", 32'(rd_raddr_wr), 0);
    chk("rel9_vld_off", 32'(alloc_vld), 0);
    alloc_req = 1'b0;

    // Double free of ID 3.
    free_wr = 1'b1;
    free_id = 6'd3;
    cyc();
    chk("rel3_raddr", 32'(rd_raddr), 32'h180);
    chk("rel3_cnt", 32'(free_cnt), 1);
    cyc();
    chk("dfree_flag", 32'(err_dfree), 1);
    chk("dfree_no_strobe", 32'(rd_raddr_wr), 0);
    chk("dfree_cnt", 32'(free_cnt), 1);

    // Out-of-range releases, including the first invalid ID.
    free_id = 6'd40;
    cyc();
    chk("range40_flag", 32'(err_range), 1);
    chk("range40_no_strobe", 32'(rd_raddr_wr), 0);
    chk("range40_cnt", 32'(free_cnt), 1);
    free_id = 6'(NUM_ID);
    cyc();
    chk("range_edge_flag", 32'(err_range), 1);
    free_wr = 1'b0;
    cyc();
    chk("range_flag_off", 32'(err_range), 0);

    random_phase(300, 70);
    random_phase(300, 30);

    // Asynchronous reset mid-run, then a full re-initialisation.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (NUM_ID + 1) cyc();
    chk("reinit_done", 32'(init_done), 1);
    chk("reinit_cnt", 32'(free_cnt), NUM_ID);
    chk("reinit_head", 32'(alloc_id), 0);

    random_phase(400, 55);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
